// File: rtl/d16_branch_pkg.sv
// Shared d16 definitions: opcode encodings, default widths and branch-kind decode types.
package d16_branch_pkg;

  localparam int D16_OPW = 8;
  localparam int D16_AW  = 16;

  localparam logic [D16_OPW-1:0] D16_OP_JMP  = 8'h01;
  localparam logic [D16_OPW-1:0] D16_OP_JMZ  = 8'h02;
  localparam logic [D16_OPW-1:0] D16_OP_JNZ  = 8'h03;
  localparam logic [D16_OPW-1:0] D16_OP_CALL = 8'h04;
  localparam logic [D16_OPW-1:0] D16_OP_RET  = 8'h05;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_JMP,
    BR_JMZ,
    BR_JNZ,
    BR_CALL,
    BR_RET
  } br_kind_e;

  // RET is only taken when there is an address to return to.
  function automatic logic branch_taken(br_kind_e kind, logic bZero, logic stackEmpty);
    logic t;
    t = 1'b0;
    case (kind)
      BR_JMP:  t = 1'b1;
      BR_JMZ:  t = bZero;
      BR_JNZ:  t = !bZero;
      BR_CALL: t = 1'b1;
      BR_RET:  t = !stackEmpty;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/d16_branch_if.sv
// Decode-side request and fetch-side redirect signals of the d16 branch unit.
interface d16_branch_if #(
  parameter int OPW = 8,
  parameter int DW  = 16,
  parameter int AW  = 16,
  parameter int SPW = 4
);
  logic           valid;
  logic [OPW-1:0] op;
  logic [AW-1:0]  a;
  logic [DW-1:0]  b;
  logic [AW-1:0]  pc_next;
  logic           li_di_rst;
  logic [AW-1:0]  mem_addr;
  logic           load;
  logic [SPW-1:0] sp;
  logic           ovf;
  logic           unf;

  modport master (
    output valid, op, a, b, pc_next,
    input  li_di_rst, mem_addr, load, sp, ovf, unf
  );

  modport slave (
    input  valid, op, a, b, pc_next,
    output li_di_rst, mem_addr, load, sp, ovf, unf
  );
endinterface

// File: rtl/d16_branch_ras.sv
// d16_ras: saturating hardware return-address stack; callers never push and pop together.
module d16_ras #(
  parameter int DEPTH = 8,
  parameter int AW    = 16,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [AW-1:0]  din,
  output logic [AW-1:0]  top,
  output logic [SPW-1:0] sp,
  output logic           full,
  output logic           empty
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [IW-1:0]  wrIdx, topIdx;

  assign full   = (sp_q == SPW'(DEPTH));
  assign empty  = (sp_q == '0);
  assign wrIdx  = IW'(sp_q);
  assign topIdx = IW'(sp_q - 1'b1);
  assign top    = empty ? '0 : mem[topIdx];
  assign sp     = sp_q;

  always_comb begin
    sp_d = sp_q;
    if (push && !full) begin
      sp_d = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage is deliberately not reset; entries at or above sp are don't-care.
  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      mem[wrIdx] <= din;
    end
  end

endmodule

// File: rtl/d16_branch.sv
// d16 branch unit: decodes JMP/JMZ/JNZ/CALL/RET, redirects fetch with zero latency and holds the flush.
module d16_branch
  import d16_branch_pkg::*;
#(
  parameter int OPW   = D16_OPW,
  parameter int DW    = 16,
  parameter int AW    = D16_AW,
  parameter int DEPTH = 8,
  parameter int FLUSH = 1
) (
  input logic          sys_clk,
  input logic          sys_rst,
  d16_branch_if.slave  bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int CW  = (FLUSH > 1) ? $clog2(FLUSH) : 1;
  localparam int OW  = (OPW > D16_OPW) ? OPW : D16_OPW;

  logic [CW-1:0] flushCnt_q, flushCnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [OW-1:0] opExt;
  br_kind_e      kind;
  logic          accept, taken, push, pop;
  logic [AW-1:0] rasTop;
  logic          rasFull, rasEmpty;

  assign opExt = OW'(bus.op);

  always_comb begin
    kind = BR_NONE;
    if      (opExt == OW'(D16_OP_JMP))  kind = BR_JMP;
    else if (opExt == OW'(D16_OP_JMZ))  kind = BR_JMZ;
    else if (opExt == OW'(D16_OP_JNZ))  kind = BR_JNZ;
    else if (opExt == OW'(D16_OP_CALL)) kind = BR_CALL;
    else if (opExt == OW'(D16_OP_RET))  kind = BR_RET;
  end

  // Ops arriving during reset or while the flush counter runs are bubbles.
  assign accept = !sys_rst && bus.valid && (flushCnt_q == '0);
  assign taken  = accept && branch_taken(kind, (bus.b == '0), rasEmpty);
  assign push   = taken && (kind == BR_CALL);
  assign pop    = taken && (kind == BR_RET);

  assign bus.load      = taken;
  assign bus.mem_addr  = !taken ? '0 : ((kind == BR_RET) ? rasTop : bus.a);
  assign bus.li_di_rst = sys_rst || taken || (flushCnt_q != '0);
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

  always_comb begin
    flushCnt_d = flushCnt_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (taken) begin
      flushCnt_d = CW'(FLUSH - 1);
    end else if (flushCnt_q != '0) begin
      flushCnt_d = flushCnt_q - 1'b1;
    end
    if (accept && (kind == BR_CALL) && rasFull) begin
      ovf_d = 1'b1;
    end
    if (accept && (kind == BR_RET) && rasEmpty) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      flushCnt_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      flushCnt_q <= flushCnt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  d16_ras #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .SPW   (SPW)
  ) u_ras (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.pc_next),
    .top   (rasTop),
    .sp    (bus.sp),
    .full  (rasFull),
    .empty (rasEmpty)
  );

endmodule
